// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative, write-back, write-allocate data cache.
// One outstanding access; misses write back a dirty victim, then fill a whole line.
module assoc_cache #(
  parameter int ADDRESS_SIZE    = 32,
  parameter int REGISTER_SIZE   = 32,
  parameter int REGS_PER_LINE   = 4,
  parameter int LINE_INDEX_SIZE = 2,
  parameter int WAYS            = 2,
  localparam int LINE_LENGTH    = REGS_PER_LINE * REGISTER_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_SIZE-1:0]  address,
  input  logic [REGISTER_SIZE-1:0] data,
  input  logic                     write,
  input  logic                     request,
  output logic [REGISTER_SIZE-1:0] result,
  output logic                     satisfied,
  output logic                     mem_request,
  output logic                     mem_write,
  output logic [ADDRESS_SIZE-1:0]  mem_address,
  output logic [LINE_LENGTH-1:0]   mem_data,
  input  logic [LINE_LENGTH-1:0]   mem_result,
  input  logic                     mem_satisfied
);

  localparam int OFFSET_BITS = $clog2(REGS_PER_LINE);
  localparam int LOW_BITS    = OFFSET_BITS + 2;
  localparam int SETS        = 2 ** LINE_INDEX_SIZE;
  localparam int TAG_SIZE    = ADDRESS_SIZE - LOW_BITS - LINE_INDEX_SIZE;
  localparam int WAY_BITS    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, DONE} state_t;

  state_t state;

  logic [LINE_LENGTH-1:0] lines      [SETS][WAYS];
  logic [TAG_SIZE-1:0]    tags       [SETS][WAYS];
  logic [WAYS-1:0]        valid_bits [SETS];
  logic [WAYS-1:0]        dirty_bits [SETS];
  logic [WAY_BITS-1:0]    rr_ptr     [SETS];

  logic [OFFSET_BITS-1:0]     word_off;
  logic [LINE_INDEX_SIZE-1:0] set_idx;
  logic [TAG_SIZE-1:0]        req_tag;
  logic [ADDRESS_SIZE-1:0]    line_addr;

  logic                     hit;
  logic [WAY_BITS-1:0]      hit_way;
  logic [LINE_LENGTH-1:0]   hit_line;
  logic [REGISTER_SIZE-1:0] hit_word;
  logic [REGISTER_SIZE-1:0] fill_word;
  logic [WAY_BITS-1:0]      victim_way;
  logic [WAY_BITS-1:0]      victim_q;

  logic                   line_we;
  logic                   tag_we;
  logic [WAY_BITS-1:0]    write_way;
  logic [LINE_LENGTH-1:0] new_line;

  logic unused_byte_bits;

  assign unused_byte_bits = ^address[1:0];

  assign word_off  = address[LOW_BITS-1:2];
  assign set_idx   = address[LOW_BITS+LINE_INDEX_SIZE-1:LOW_BITS];
  assign req_tag   = address[ADDRESS_SIZE-1:LOW_BITS+LINE_INDEX_SIZE];
  assign line_addr = {req_tag, set_idx, {LOW_BITS{1'b0}}};

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_bits[set_idx][w] && (tags[set_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  assign hit_line  = lines[set_idx][hit_way];
  assign hit_word  = hit_line[word_off*REGISTER_SIZE +: REGISTER_SIZE];
  assign fill_word = mem_result[word_off*REGISTER_SIZE +: REGISTER_SIZE];

  // Lowest-numbered invalid way wins; only a full set falls back to round-robin.
  always_comb begin
    victim_way = rr_ptr[set_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_bits[set_idx][w]) begin
        victim_way = WAY_BITS'(w);
      end
    end
  end

  // A store merges into the hit line, or into the freshly filled line on a miss.
  always_comb begin
    line_we   = 1'b0;
    tag_we    = 1'b0;
    write_way = hit_way;
    new_line  = hit_line;
    if (state == IDLE && request && hit && write) begin
      line_we = 1'b1;
    end else if (state == FILL && mem_request && mem_satisfied) begin
      line_we   = 1'b1;
      tag_we    = 1'b1;
      write_way = victim_q;
      new_line  = mem_result;
    end
    if (write) begin
      new_line[word_off*REGISTER_SIZE +: REGISTER_SIZE] = data;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      lines[set_idx][write_way] <= new_line;
      if (tag_we) begin
        tags[set_idx][write_way] <= req_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      satisfied   <= 1'b0;
      mem_request <= 1'b0;
      mem_write   <= 1'b0;
      result      <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      victim_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_bits[s] <= '0;
        dirty_bits[s] <= '0;
        rr_ptr[s]     <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          satisfied <= 1'b0;
          if (request) begin
            if (hit) begin
              if (write) begin
                dirty_bits[set_idx][hit_way] <= 1'b1;
              end else begin
                result <= hit_word;
              end
              state <= DONE;
            end else begin
              victim_q    <= victim_way;
              mem_request <= 1'b1;
              if (valid_bits[set_idx][victim_way] && dirty_bits[set_idx][victim_way]) begin
                state       <= WRITEBACK;
                mem_write   <= 1'b1;
                mem_address <= {tags[set_idx][victim_way], set_idx, {LOW_BITS{1'b0}}};
                mem_data    <= lines[set_idx][victim_way];
              end else begin
                state       <= FILL;
                mem_write   <= 1'b0;
                mem_address <= line_addr;
              end
            end
          end
        end
        // Request drops for one cycle between writeback and fill so each is a distinct transaction.
        WRITEBACK: begin
          if (mem_satisfied) begin
            state       <= FILL;
            mem_request <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= line_addr;
          end
        end
        FILL: begin
          if (mem_request && mem_satisfied) begin
            mem_request                   <= 1'b0;
            valid_bits[set_idx][victim_q] <= 1'b1;
            dirty_bits[set_idx][victim_q] <= write;
            if (valid_bits[set_idx][victim_q]) begin
              rr_ptr[set_idx] <= (WAYS == 1) ? '0 : victim_q + 1'b1;
            end
            if (!write) begin
              result <= fill_word;
            end
            state <= DONE;
          end else begin
            mem_request <= 1'b1;
          end
        end
        DONE: begin
          satisfied <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
